// File: rtl/binary_rle.sv
// Binary run-length encoder: collapses a pixel stream into {value, length, last} runs
// and queues them in a small output FIFO that can absorb two runs per cycle.
module binary_rle #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bin_in,
  input  logic                          bin_valid,
  input  logic                          line_end,
  output logic [8:0]                    run_data,
  output logic                          run_last,
  output logic                          run_valid,
  input  logic                          run_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_cur_val;
  logic           w_cur_val_nxt;
  logic [7:0]     r_cur_len;
  logic [7:0]     w_cur_len_nxt;

  // Entry layout: [9]=last, [8]=pixel value, [7:0]=run length
  logic           w_push0;
  logic           w_push1;
  logic [9:0]     w_ent0;
  logic [9:0]     w_ent1;

  logic [9:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  w_wr_ptr1;
  logic [LW-1:0]  r_level;
  logic [LW-1:0]  w_level_nxt;
  logic [LW-1:0]  w_free;
  logic [1:0]     w_req;
  logic [1:0]     w_writes;
  logic           w_pop;
  logic           w_drop;
  logic           w_wr0;
  logic           w_wr1;
  logic           r_overflow;

  // Run tracker: decides the next open run and which entries close this cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_val_nxt = r_cur_val;
    w_cur_len_nxt = r_cur_len;
    w_push0       = 1'b0;
    w_push1       = 1'b0;
    w_ent0        = 10'd0;
    w_ent1        = 10'd0;
    if (bin_valid) begin
      case (r_state)
        S_IDLE: begin
          if (line_end) begin
            w_push0 = 1'b1;
            w_ent0  = {1'b1, bin_in, 8'd1};
          end else begin
            w_state_nxt   = S_RUN;
            w_cur_val_nxt = bin_in;
            w_cur_len_nxt = 8'd1;
          end
        end
        S_RUN: begin
          if ((bin_in == r_cur_val) && (r_cur_len != 8'd255)) begin
            if (line_end) begin
              w_push0     = 1'b1;
              w_ent0      = {1'b1, r_cur_val, r_cur_len + 8'd1};
              w_state_nxt = S_IDLE;
            end else begin
              w_cur_len_nxt = r_cur_len + 8'd1;
            end
          end else begin
            // Value change or saturated length closes the current run first
            w_push0 = 1'b1;
            w_ent0  = {1'b0, r_cur_val, r_cur_len};
            if (line_end) begin
              w_push1     = 1'b1;
              w_ent1      = {1'b1, bin_in, 8'd1};
              w_state_nxt = S_IDLE;
            end else begin
              w_cur_val_nxt = bin_in;
              w_cur_len_nxt = 8'd1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Run tracker state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cur_val <= 1'b0;
      r_cur_len <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_val <= w_cur_val_nxt;
      r_cur_len <= w_cur_len_nxt;
    end
  end

  // Space accounting: a pop in the same cycle frees a slot for an incoming entry
  always_comb begin
    w_pop     = (r_level != {LW{1'b0}}) && run_ready;
    w_free    = LW'(FIFO_DEPTH) - r_level + LW'(w_pop);
    w_req     = {1'b0, w_push0} + {1'b0, w_push1};
    w_wr_ptr1 = r_wr_ptr + AW'(1'b1);
    if (LW'(w_req) > w_free) begin
      w_drop   = 1'b1;
      w_writes = w_free[1:0];
    end else begin
      w_drop   = 1'b0;
      w_writes = w_req;
    end
    w_wr0       = (w_writes != 2'd0);
    w_wr1       = (w_writes == 2'd2);
    w_level_nxt = r_level + LW'(w_writes) - LW'(w_pop);
  end

  // FIFO storage and pointers; entries are written in push order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 10'd0;
      end
      r_rd_ptr   <= {AW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_level    <= {LW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_wr0) begin
        r_mem[r_wr_ptr] <= w_ent0;
      end
      if (w_wr1) begin
        r_mem[w_wr_ptr1] <= w_ent1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_wr_ptr <= r_wr_ptr + AW'(w_writes);
      r_level  <= w_level_nxt;
    end
  end

  // Head view of the FIFO
  always_comb begin
    run_data   = r_mem[r_rd_ptr][8:0];
    run_last   = r_mem[r_rd_ptr][9];
    run_valid  = (r_level != {LW{1'b0}});
    fifo_level = r_level;
    overflow   = r_overflow;
  end

endmodule

// File: tb/tb_binary_rle.sv
// Self-checking bench for binary_rle: cycle-level reference model with an
// expected-entry queue, a table-driven line sequence and hand-written corner cases.
module tb_binary_rle;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          bin_in = 1'b0;
  logic          bin_valid = 1'b0;
  logic          line_end = 1'b0;
  logic          run_ready = 1'b0;
  logic [8:0]    run_data;
  logic          run_last;
  logic          run_valid;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [9:0] mq[$];
  logic [9:0] dut_log[$];
  bit         movf;
  bit         m_run;
  bit         m_val;
  int         m_len;

  typedef struct {
    bit b;
    bit v;
    bit le;
    bit rdy;
    int lvl;
  } vec_t;

  vec_t tbl[16];

  binary_rle #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin_in    (bin_in),
    .bin_valid (bin_valid),
    .line_end  (line_end),
    .run_data  (run_data),
    .run_last  (run_last),
    .run_valid (run_valid),
    .run_ready (run_ready),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mpush(input logic [9:0] e);
    if (mq.size() < DEPTH) mq.push_back(e);
    else movf = 1'b1;
  endtask

  // Reference behaviour for one clock edge with the given inputs
  task automatic model(input bit b, input bit v, input bit le, input bit rdy);
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (v) begin
      if (!m_run) begin
        if (le) mpush({1'b1, b, 8'd1});
        else begin m_run = 1'b1; m_val = b; m_len = 1; end
      end else if (b == m_val && m_len < 255) begin
        if (le) begin mpush({1'b1, m_val, 8'(m_len + 1)}); m_run = 1'b0; end
        else m_len++;
      end else begin
        mpush({1'b0, m_val, 8'(m_len)});
        if (le) begin mpush({1'b1, b, 8'd1}); m_run = 1'b0; end
        else begin m_val = b; m_len = 1; end
      end
    end
  endtask

  // Called at a falling edge: drive, record pops, clock, compare against the model
  task automatic cyc(input bit b, input bit v, input bit le, input bit rdy);
    bin_in = b; bin_valid = v; line_end = le; run_ready = rdy;
    if (run_valid && rdy) dut_log.push_back({run_last, run_data});
    model(b, v, le, rdy);
    @(posedge clk);
    @(negedge clk);
    chk("run_valid", int'(run_valid), int'(mq.size() != 0));
    chk("fifo_level", int'(fifo_level), mq.size());
    chk("overflow", int'(overflow), int'(movf));
    if (mq.size() != 0) chk("head", int'({run_last, run_data}), int'(mq[0]));
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0; bin_valid = 1'b0; line_end = 1'b0; bin_in = 1'b0; run_ready = 1'b0;
    #1;
    chk("rst_valid", int'(run_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_data", int'(run_data), 0);
    chk("rst_last", int'(run_last), 0);
    chk("rst_overflow", int'(overflow), 0);
    mq.delete(); movf = 1'b0; m_run = 1'b0; m_val = 1'b0; m_len = 0;
    dut_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_log(input string name, input logic [9:0] e[$]);
    chk({name, "_count"}, dut_log.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < dut_log.size()) chk({name, "_entry"}, int'(dut_log[i]), int'(e[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] exp_q[$];

    // b, v, le, rdy, expected level after the edge
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 3};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 0};

    do_reset();

    // Line 1,1,1,0,0,0(end); invalid cycle; IDLE end pixel; RUN {0,4} closed by a 1 with line_end
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].b, tbl[i].v, tbl[i].le, tbl[i].rdy);
      chk("tbl_level", int'(fifo_level), tbl[i].lvl);
    end
    exp_q = '{10'h103, 10'h203, 10'h201, 10'h004, 10'h301};
    chk_log("table", exp_q);

    // 300 ones with line_end on the last: length saturates at 255
    do_reset();
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, (i == 299), 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    exp_q = '{10'h1FF, 10'h32D};
    chk_log("long_run", exp_q);

    // Stalled output with alternating pixels: fill, then overflow
    do_reset();
    for (int i = 0; i < 5; i++) cyc(i[0], 1'b1, 1'b0, 1'b0);
    chk("fill_level", int'(fifo_level), 4);
    chk("fill_overflow", int'(overflow), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_level", int'(fifo_level), 4);
    chk("ovf_head", int'({run_last, run_data}), 10'h001);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_sticky", int'(overflow), 1);
    exp_q = '{10'h001, 10'h101, 10'h001, 10'h101};
    chk_log("ovf_drain", exp_q);

    // Full FIFO with a pop every cycle absorbs one push per cycle
    do_reset();
    for (int i = 0; i < 5; i++) cyc(i[0], 1'b1, 1'b0, 1'b0);
    for (int i = 5; i < 11; i++) cyc(i[0], 1'b1, 1'b0, 1'b1);
    chk("full_pop_level", int'(fifo_level), 4);
    chk("full_pop_overflow", int'(overflow), 0);

    // Reset mid-run with three entries queued, then a fresh line
    do_reset();
    for (int i = 0; i < 4; i++) cyc(i[0], 1'b1, 1'b0, 1'b0);
    chk("pre_rst_level", int'(fifo_level), 3);
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    exp_q = '{10'h302};
    chk_log("post_rst", exp_q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_rle.md
BINARY_RLE -- requirements
Module: binary_rle

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, output FIFO entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 bin_in  input  1  binary pixel from the threshold stage.
REQ-005 bin_valid  input  1  bin_in qualifier.
REQ-006 line_end  input  1  marks the last pixel of a line; meaningful only when bin_valid=1.
REQ-007 run_data  output  9  head run: [8]=pixel value, [7:0]=run length, 1..255.
REQ-008 run_last  output  1  head run was closed by line_end.
REQ-009 run_valid  output  1  head entry present.
REQ-010 run_ready  input  1  downstream accepts the head entry.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-012 overflow  output  1  sticky flag: an entry was dropped.

Function
REQ-013 Input path SHALL have no backpressure; one pixel SHALL be consumed on every cycle with bin_valid=1.
REQ-014 States SHALL be IDLE (no open run) and RUN (open run holding cur_val and cur_len, 1..255).
REQ-015 bin_valid=0: run state SHALL be unchanged; line_end SHALL be ignored.
REQ-016 IDLE with bin_valid=1 and line_end=0: SHALL open a run {bin_in, 1} and go to RUN.
REQ-017 IDLE with bin_valid=1 and line_end=1: SHALL push {bin_in, 1, last=1} and stay in IDLE.
REQ-018 RUN with bin_in==cur_val and cur_len<255: SHALL set cur_len+1.
- If line_end=1 in the same cycle, SHALL instead push {cur_val, cur_len+1, last=1} and go to IDLE.
REQ-019 RUN with bin_in!=cur_val, or with cur_len==255: SHALL push {cur_val, cur_len, last=0} and open a new run {bin_in, 1}.
- If line_end=1 in the same cycle, SHALL also push {bin_in, 1, last=1}, after the first entry, and go to IDLE.
REQ-020 FIFO SHALL accept 0, 1 or 2 pushes per cycle, in order; entries SHALL never be reordered.
REQ-021 run_valid SHALL equal (fifo_level != 0); run_data and run_last SHALL show the head entry.
- A pop SHALL occur when run_valid and run_ready are both 1.
REQ-022 A pushed entry SHALL be visible at the head no earlier than the cycle after the push (latency 1 when the FIFO is empty).
REQ-023 Free space SHALL be computed as FIFO_DEPTH - fifo_level + pop (a same-cycle pop frees one slot).
REQ-024 When pushes exceed free space:
- SHALL write entries in order until full, then drop the remainder.
- SHALL set overflow to 1.
- Run state SHALL still advance per REQ-016..019.
REQ-025 overflow SHALL be cleared only by reset.
REQ-026 fifo_level SHALL equal previous level + writes - pop, and SHALL never exceed FIFO_DEPTH.
REQ-027 Head outputs SHALL stay stable while run_valid=1 and run_ready=0.

Reset
REQ-028 rst_n=0 SHALL immediately set: state IDLE, fifo_level 0, run_valid 0, run_data 0, run_last 0, overflow 0.
REQ-029 rst_n=0 SHALL discard the open run and all FIFO contents.
REQ-030 The first pixel with bin_valid=1 after rst_n deasserts SHALL be treated per REQ-016/017.

Verification
REQ-031 Scenario: run_ready=1; input 1,1,1,0,0 then 0 with line_end -> entries {1,3,0} then {0,3,1}.
REQ-032 Scenario: 300 consecutive 1s, line_end on the last one -> entries {1,255,0} then {1,45,1}.
REQ-033 Scenario: RUN holding {0,4}; bin_in=1 with line_end in one cycle -> {0,4,0} and {1,1,1} pushed in the same cycle, then popped in that order.
REQ-034 Scenario: run_ready=0, FIFO_DEPTH=4, alternating 0/1 pixels -> fifo_level saturates at 4; overflow=1 at the next push; head stays {first value,1,0}.
REQ-035 Scenario: FIFO full with run_ready=1, one push per cycle -> level stays 4 and overflow stays 0 (same-cycle pop frees a slot).
REQ-036 Scenario: rst_n asserted mid-run with 3 entries queued -> run_valid=0 and fifo_level=0 with no clock edge; the next line encodes from a fresh run.
